hex_counter_n: RTL and testbench
================================

# hex_counter_n

Parametrised N-digit hexadecimal counter with direct seven-segment outputs. It is the general successor of the lab's fixed 8-bit toggle-enable counter. It adds:
- configurable digit count and terminal value;
- up/down counting, synchronous clear and parallel load;
- wrap or saturate mode, a terminal-count pulse and optional leading-zero blanking.

It sits between board inputs (pushbutton clock or debounced strobe, switches) and the HEX display banks.

## Interface
Parameters:
- DIGITS, default 2: number of hex digits; counter width W = 4*DIGITS.
- MAX, default 2**(4*DIGITS)-1: terminal (largest) count value; must satisfy 1 <= MAX <= 2**W-1.
- SATURATE, default 0: 0 = wrap at the limits, 1 = hold at the limits.
- LZB, default 0: 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- R  input  1  reset, asynchronous and active-low.
- clr  input  1  synchronous clear to 0.
- ld  input  1  synchronous parallel load.
- d  input  W  load value.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- q  output  W  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- hex  output  7*DIGITS  segments, active-low. Digit k occupies hex[7k+6:7k], ordered {g,f,e,d,c,b,a}.

## Operation
- R low: q=0 and tc=0 immediately, independent of clk. hex then shows 0 on every digit (7'b1000000 each), or blanks digits 1..DIGITS-1 (7'b1111111) when LZB=1.
- Per rising edge with R high, the priority is clr > ld > en. One action at most per edge.
  - clr=1: q <= 0, tc <= 0.
  - ld=1: q <= min(d, MAX), tc <= 0. A value above MAX clamps to MAX.
  - en=1, up=1, q<MAX: q <= q+1, tc <= 0.
  - en=1, up=1, q==MAX: q <= 0 (SATURATE=0) or q <= MAX (SATURATE=1). tc <= 1 in both modes.
  - en=1, up=0, q>0: q <= q-1, tc <= 0.
  - en=1, up=0, q==0: q <= MAX (SATURATE=0) or q <= 0 (SATURATE=1). tc <= 1 in both modes.
  - No action: q holds, tc <= 0.
- tc therefore rises for exactly one cycle per limit event. In saturate mode, holding en at the limit produces tc=1 on every enabled edge.
- Arithmetic is W-bit unsigned. Wrap and saturate decisions compare against MAX and 0, never against 2**W.
- hex decode is combinational from q, giving standard 0-F glyphs: b and d lowercase, the rest uppercase.
- LZB=1: digit k (k>=1) is blanked iff it and every digit above it are 0.

## Timing
- Count, load and clear each take effect at the edge where they are sampled; q is valid one clk edge after the input is sampled.
- tc is asserted in the same cycle as the q value produced by the limit event.
- hex follows q combinationally; it is valid in the same cycle as q, with no additional register stage.
- Reset assertion mid-count aborts the operation and forces the reset values asynchronously. On deassertion, the first active edge uses normal priority.
- Inputs are assumed synchronous to clk. Pushbutton sources must be synchronised and debounced upstream.

## Structure
- Shared package seg7_pkg:
  - 7-bit segment type;
  - constants SEG_BLANK = 7'b1111111 and SEG_ZERO = 7'b1000000;
  - the 16-entry glyph table.
- Sub-module hex_to_seg7 (4-bit in, 7-bit active-low out, purely combinational), instantiated DIGITS times via generate.
- The counter register, limit comparison, tc register and blanking logic live in hex_counter_n.

## Test plan
- Reset: DIGITS=2, run to q=8'h37, pull R low between edges. Required: q=0 and tc=0 without a clock edge; hex=14'b1000000_1000000.
- Wrap up: DIGITS=2, MAX=8'h59, SATURATE=0, load 8'h58, en=1, up=1 for 3 edges. Required: q = 59, 00, 01; tc=1 only with q=00.
- Saturate down: SATURATE=1, load 8'h01, up=0, en=1 for 3 edges. Required: q = 00, 00, 00; tc = 0, 1, 1.
- Priority: clr=ld=en=1 with d=8'hAA. Required: q=0. Then ld=en=1, d=8'hFF, MAX=8'hC7. Required: q=8'hC7 (clamped), tc=0.
- Blanking: DIGITS=4, LZB=1, load 16'h00A0. Required: digits 3 and 2 = 7'b1111111, digit 1 = 'A' glyph 7'b0001000, digit 0 = 7'b1000000. Load 16'h0000: only digit 0 lit.
- Decode sweep: DIGITS=1, count 0..F. Required: each hex value matches the glyph table, and tc=1 with q=0 after F.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared seven-segment types, constants and hex glyph table.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_ZERO  = 7'b1000000;

  // Index 15 first: b and d are lowercase so they stay distinct from 8 and 0.
  localparam seg7_t [15:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic seg7_t seg7_glyph(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational 4-bit hex to active-low seven-segment decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg7_t      seg
);

  assign seg = seg7_glyph(nib);

endmodule
`default_nettype wire

// File: rtl/hex_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : hex_counter_n
//  Description : N-digit up/down hex counter with clear, clamped load,
//                wrap/saturate limits, terminal-count pulse and direct
//                seven-segment outputs with optional leading-zero blanking.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_counter_n
  import seg7_pkg::*;
#(
  parameter int                  DIGITS   = 2,
  parameter logic [4*DIGITS-1:0] MAX      = {(4*DIGITS){1'b1}},
  parameter bit                  SATURATE = 1'b0,
  parameter bit                  LZB      = 1'b0
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_q;
  logic         r_tc;
  logic [W-1:0] w_q_nxt;
  logic         w_tc_nxt;
  logic         w_at_max;
  logic         w_at_zero;
  logic [W-1:0] w_ld_val;

  assign w_at_max  = (r_q == MAX);
  assign w_at_zero = (r_q == '0);
  assign w_ld_val  = (d > MAX) ? MAX : d;

  // Limits are MAX and 0, never the natural 2**W rollover.
  always_comb begin
    w_q_nxt  = r_q;
    w_tc_nxt = 1'b0;
    if (clr) begin
      w_q_nxt = '0;
    end else if (ld) begin
      w_q_nxt = w_ld_val;
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
          w_q_nxt  = SATURATE ? MAX : '0;
          w_tc_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q + 1'b1;
        end
      end else begin
        if (w_at_zero) begin
          w_q_nxt  = SATURATE ? '0 : MAX;
          w_tc_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_tc <= w_tc_nxt;
    end
  end

  assign q  = r_q;
  assign tc = r_tc;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_t w_glyph;

    hex_to_seg7 u_dec (
      .nib (r_q[4*k +: 4]),
      .seg (w_glyph)
    );

    if (k == 0 || !LZB) begin : g_lit
      assign hex[7*k +: 7] = w_glyph;
    end else begin : g_blank
      // Blank only when this digit and all digits above it are zero.
      logic w_upper_zero;
      assign w_upper_zero  = (r_q[W-1:4*k] == '0);
      assign hex[7*k +: 7] = w_upper_zero ? SEG_BLANK : w_glyph;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_counter_n
//  Description : Directed self-checking bench over several hex_counter_n builds.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hex_counter_n;

  logic        clk = 1'b0;
  logic        R;
  logic        clr;
  logic        up;
  logic [15:0] d;
  logic [4:0]  ld;
  logic [4:0]  en;

  logic [7:0]  q0, q1, q2;
  logic [15:0] q3;
  logic [3:0]  q4;
  logic [4:0]  tc;
  logic [13:0] hex0, hex1, hex2;
  logic [27:0] hex3;
  logic [6:0]  hex4;

  int checks   = 0;
  int failures = 0;

  logic [6:0] glyph [16];
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] Z0 = 7'b1000000;

  always #5 clk = ~clk;

  // u0: wrap, MAX=59
  hex_counter_n #(.DIGITS(2), .MAX(8'h59), .SATURATE(1'b0), .LZB(1'b0)) u0 (
    .clk(clk), .R(R), .clr(clr), .ld(ld[0]), .d(d[7:0]), .en(en[0]), .up(up),
    .q(q0), .tc(tc[0]), .hex(hex0));
  // u1: saturate, default MAX=FF
  hex_counter_n #(.DIGITS(2), .SATURATE(1'b1)) u1 (
    .clk(clk), .R(R), .clr(clr), .ld(ld[1]), .d(d[7:0]), .en(en[1]), .up(up),
    .q(q1), .tc(tc[1]), .hex(hex1));
  // u2: wrap, MAX=C7 for load clamping
  hex_counter_n #(.DIGITS(2), .MAX(8'hC7)) u2 (
    .clk(clk), .R(R), .clr(clr), .ld(ld[2]), .d(d[7:0]), .en(en[2]), .up(up),
    .q(q2), .tc(tc[2]), .hex(hex2));
  // u3: four digits with leading-zero blanking
  hex_counter_n #(.DIGITS(4), .LZB(1'b1)) u3 (
    .clk(clk), .R(R), .clr(clr), .ld(ld[3]), .d(d), .en(en[3]), .up(up),
    .q(q3), .tc(tc[3]), .hex(hex3));
  // u4: single digit for the decode sweep
  hex_counter_n #(.DIGITS(1)) u4 (
    .clk(clk), .R(R), .clr(clr), .ld(ld[4]), .d(d[3:0]), .en(en[4]), .up(up),
    .q(q4), .tc(tc[4]), .hex(hex4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100;
    glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
    glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
    glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110;
    glyph[15] = 7'b0001110;

    R = 1'b0; clr = 1'b0; up = 1'b1; d = '0; ld = '0; en = '0;
    #2;
    chk("rst_q0",   {24'd0, q0}, 32'h0);
    chk("rst_tc",   {27'd0, tc}, 32'h0);
    chk("rst_hex0", {18'd0, hex0}, {18'd0, Z0, Z0});
    chk("rst_hex3", {4'd0, hex3}, {4'd0, BL, BL, BL, Z0});
    @(negedge clk);
    R = 1'b1;

    // Run to 37, then async reset between edges
    ld[0] = 1'b1; d = 16'h0035;
    tick();
    chk("ld35_q0", {24'd0, q0}, 32'h35);
    ld[0] = 1'b0; en[0] = 1'b1; up = 1'b1;
    tick(); tick();
    chk("run37_q0", {24'd0, q0}, 32'h37);
    en[0] = 1'b0;
    #3 R = 1'b0;
    #1;
    chk("async_q0",   {24'd0, q0}, 32'h0);
    chk("async_tc0",  {31'd0, tc[0]}, 32'h0);
    chk("async_hex0", {18'd0, hex0}, {18'd0, Z0, Z0});
    #1 R = 1'b1;

    // Wrap up at MAX=59, then wrap down through 0
    ld[0] = 1'b1; d = 16'h0058;
    tick();
    chk("ld58_q0", {24'd0, q0}, 32'h58);
    ld[0] = 1'b0; en[0] = 1'b1; up = 1'b1;
    tick();
    chk("wrap1_q0",  {24'd0, q0}, 32'h59);
    chk("wrap1_tc0", {31'd0, tc[0]}, 32'h0);
    chk("hex59",     {18'd0, hex0}, {18'd0, glyph[5], glyph[9]});
    tick();
    chk("wrap2_q0",  {24'd0, q0}, 32'h00);
    chk("wrap2_tc0", {31'd0, tc[0]}, 32'h1);
    tick();
    chk("wrap3_q0",  {24'd0, q0}, 32'h01);
    chk("wrap3_tc0", {31'd0, tc[0]}, 32'h0);
    up = 1'b0;
    tick();
    chk("dn1_q0",  {24'd0, q0}, 32'h00);
    chk("dn1_tc0", {31'd0, tc[0]}, 32'h0);
    tick();
    chk("dn2_q0",  {24'd0, q0}, 32'h59);
    chk("dn2_tc0", {31'd0, tc[0]}, 32'h1);
    en[0] = 1'b0;
    tick();
    chk("hold_q0",  {24'd0, q0}, 32'h59);
    chk("hold_tc0", {31'd0, tc[0]}, 32'h0);

    // Saturate down and up
    ld[1] = 1'b1; d = 16'h0001;
    tick();
    ld[1] = 1'b0; en[1] = 1'b1; up = 1'b0;
    tick();
    chk("sat1_q1",  {24'd0, q1}, 32'h00);
    chk("sat1_tc1", {31'd0, tc[1]}, 32'h0);
    tick();
    chk("sat2_q1",  {24'd0, q1}, 32'h00);
    chk("sat2_tc1", {31'd0, tc[1]}, 32'h1);
    tick();
    chk("sat3_q1",  {24'd0, q1}, 32'h00);
    chk("sat3_tc1", {31'd0, tc[1]}, 32'h1);
    en[1] = 1'b0; ld[1] = 1'b1; d = 16'h00FE;
    tick();
    ld[1] = 1'b0; en[1] = 1'b1; up = 1'b1;
    tick();
    chk("satu1_q1",  {24'd0, q1}, 32'hFF);
    chk("satu1_tc1", {31'd0, tc[1]}, 32'h0);
    tick();
    chk("satu2_q1",  {24'd0, q1}, 32'hFF);
    chk("satu2_tc1", {31'd0, tc[1]}, 32'h1);

    // Priority: clr beats ld and en
    clr = 1'b1; ld[1] = 1'b1; d = 16'h00AA;
    tick();
    chk("prio_q1",  {24'd0, q1}, 32'h00);
    chk("prio_tc1", {31'd0, tc[1]}, 32'h0);
    clr = 1'b0; ld[1] = 1'b0; en[1] = 1'b0;

    // Clamped load beats en; then wrap at C7
    ld[2] = 1'b1; en[2] = 1'b1; up = 1'b1; d = 16'h00FF;
    tick();
    chk("clamp_q2",  {24'd0, q2}, 32'hC7);
    chk("clamp_tc2", {31'd0, tc[2]}, 32'h0);
    ld[2] = 1'b0;
    tick();
    chk("c7wrap_q2",  {24'd0, q2}, 32'h00);
    chk("c7wrap_tc2", {31'd0, tc[2]}, 32'h1);
    ld[2] = 1'b1; d = 16'h0010;
    tick();
    chk("ld_over_en_q2", {24'd0, q2}, 32'h10);
    ld[2] = 1'b0; en[2] = 1'b0;

    // Leading-zero blanking
    ld[3] = 1'b1; d = 16'h00A0;
    tick();
    chk("lzb_a0_q3",  {16'd0, q3}, 32'h00A0);
    chk("lzb_a0_hex", {4'd0, hex3}, {4'd0, BL, BL, 7'b0001000, Z0});
    d = 16'h0000;
    tick();
    chk("lzb_00_hex", {4'd0, hex3}, {4'd0, BL, BL, BL, Z0});
    d = 16'h1000;
    tick();
    chk("lzb_1000_hex", {4'd0, hex3}, {4'd0, glyph[1], Z0, Z0, Z0});
    ld[3] = 1'b0;

    // Decode sweep on the single-digit counter
    chk("sweep0_hex", {25'd0, hex4}, {25'd0, glyph[0]});
    en[4] = 1'b1; up = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("sweep_q4",   {28'd0, q4}, i);
      chk("sweep_hex4", {25'd0, hex4}, {25'd0, glyph[i]});
      chk("sweep_tc4",  {31'd0, tc[4]}, 32'h0);
    end
    tick();
    chk("sweepF_q4",   {28'd0, q4}, 32'h0);
    chk("sweepF_tc4",  {31'd0, tc[4]}, 32'h1);
    chk("sweepF_hex4", {25'd0, hex4}, {25'd0, Z0});
    en[4] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
